score_reset_char_gen: RTL and testbench
=======================================

# score_reset_char_gen

Character/font responder for the end-of-game score panel overlay. It serves the overlay's `char_yx`/`char_line` requests with 40-pixel glyph rows (`char_pixels`) at the two-cycle alignment the overlay expects. It owns the panel text: a GAME OVER / YOU WIN banner, a four-digit score and a reset prompt. On each game end it converts the binary score to BCD with a sequential double-dabble engine.

## Interface
- `SCORE_W`, 14: width of binary score input.
- `SCALE`, 5: glyph magnification (8x8 base font to 40x40 cell).
- `pclk`  in  1  pixel clock; only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `char_yx`  in  8  {row[3:0], col[3:0]} of the requested cell; sampled every cycle.
- `char_line`  in  8  line within the cell, 0..39; used in the output cycle.
- `score`  in  SCORE_W  binary score; sampled on game-end rising edge only.
- `game_over`, `victory`  in  1 each  end flags; `game_over` has priority.
- `char_pixels`  out  40  glyph row; bit 39 is the leftmost pixel.
- `digits_valid`  out  1  BCD score digits are current.

## Operation
- Text grid: 16 cols × 6 rows; rows 6..15 are blank. Row 1 shows `"   GAME  OVER   "` if `game_over`, else `"    YOU  WIN    "` if `victory`, else blank. Row 3 shows `"   SCORE  NNNN  "`, with the digits in cols 10..13. Row 4 shows `"  PRESS  RESET  "`. Every other cell is a space.
- Char codes are 6 bit: space=0, '0'..'9'=1..10, 'A'..'Z'=11..36. Unused codes render blank.
- Digits: leading zeros are shown as spaces; the units digit always shows. All four digits are spaces while `digits_valid`=0.
- Glyph row: `r = char_line / SCALE`. If `char_line` ≥ 40, output 0. Otherwise `f` = font row r of the code, and `char_pixels[39-i] = f[7 - i/SCALE]` for i=0..39.
- BCD FSM states:
  - IDLE → LOAD on the rising edge of `g = game_over|victory`, taken as `g & ~g_q`.
  - LOAD: load the shift register with `min(score, 9999)`, clear the counter, go to SHIFT.
  - SHIFT: one double-dabble step per cycle (add 3 to any nibble ≥5, then shift left 1). After 14 steps, write the digits register and set `digits_valid`; go to DONE.
  - DONE: hold. Go to IDLE when `g`=0.
- Abort: if `g` falls in LOAD or SHIFT, go to IDLE. The digits register is left unchanged and `digits_valid` stays 0. A new rising edge is required to convert again.
- `digits_valid` clears on entry to IDLE.

## Timing
- Request path:
  - `char_yx` at cycle t is registered to a cell code at t+1, then re-registered at t+2.
  - `char_pixels` at t+2 is a combinational font lookup of the t+2 code register and the current `char_line`. This is the only combinational input-to-output path.
- The banner and digit selection use the flag and digit values registered at t+1.
- Conversion:
  - Rising edge of `g` is sampled at edge E (state←LOAD).
  - LOAD executes at E+1.
  - 14 SHIFT steps execute at E+2..E+15.
  - `digits_valid` is 1 from E+15.
- Reset (`rst_n`=0 at an edge), from any state including mid-conversion:
  - State←IDLE, `g_q`←0, digits←0, `digits_valid`←0.
  - Code pipeline←space, so `char_pixels`=0 until new requests propagate (2 cycles).
- `score` changes after LOAD have no effect on the current conversion.

## Structure
- Package `score_reset_pkg`:
  - char code constants (`CH_SPACE`, `CH_0`, `CH_A`);
  - FSM state encoding (IDLE/LOAD/SHIFT/DONE);
  - panel geometry (`COLS`=16, `ROWS`=6, `CELL`=40);
  - `MAX_SCORE`=9999.
- Sub-module `font_8x8_rom`: 6-bit code + 3-bit row → 8-bit row, combinational case table.
- The top holds the text-map decode, the two-stage code pipeline, the scaler and the BCD FSM.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then sweep `char_yx` over 0x00..0x5F. Require `char_pixels`=0 throughout and `digits_valid`=0.
- Conversion: `score`=1234, raise `game_over` at edge E. Require `digits_valid` rises at E+15. Then `char_yx`=0x3A, `char_line`=0 two cycles later must give the glyph '1' row 0, 5× scaled.
- Blanking and saturation:
  - `score`=7: cells 0x3A..0x3C = 0, cell 0x3D = glyph '7'.
  - `score`=12000: digits display 9999.
- Priority and latency: `game_over`=`victory`=1; row 1 col 3 must be 'G'. Step `char_yx` every cycle and check `char_pixels` follows with exactly 2-cycle latency.
- Abort: drop `game_over` at E+8. Require IDLE and `digits_valid` stays 0. Re-raise it; a fresh conversion must complete 15 cycles later with the new `score`.
- Bounds: `char_line`=40, and row 7 with any column; both must give `char_pixels`=0.

Source files
------------

// File: rtl/score_reset_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_reset_pkg
//  Description : Shared definitions for the end-of-game score panel character
//                generator: character codes, BCD FSM states, panel geometry,
//                the fixed panel text lines and ASCII-to-code helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package score_reset_pkg;

  // Character codes: space=0, '0'..'9'=1..10, 'A'..'Z'=11..36.
  localparam logic [5:0] CH_SPACE = 6'd0;
  localparam logic [5:0] CH_0     = 6'd1;
  localparam logic [5:0] CH_A     = 6'd11;

  // Panel geometry in cells and pixels.
  localparam int COLS = 16;
  localparam int ROWS = 6;
  localparam int CELL = 40;

  // Highest score the four-digit display can show.
  localparam int MAX_SCORE = 9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } bcd_state_t;

  // Fixed panel lines, one ASCII byte per column, column 0 in the top byte.
  // The score line carries spaces where the four digits are overlaid.
  localparam logic [8*COLS-1:0] c_txt_game_over = "   GAME  OVER   ";
  localparam logic [8*COLS-1:0] c_txt_you_win   = "    YOU  WIN    ";
  localparam logic [8*COLS-1:0] c_txt_score     = "   SCORE        ";
  localparam logic [8*COLS-1:0] c_txt_press     = "  PRESS  RESET  ";

  // Pick the ASCII byte of one column out of a panel line.
  function automatic logic [7:0] text_char(input logic [8*COLS-1:0] text,
                                           input logic [3:0]        col);
    return text[8*(COLS-1-int'(col)) +: 8];
  endfunction

  // Map ASCII to the 6-bit font code; anything not a digit or capital is space.
  function automatic logic [5:0] ascii_to_code(input logic [7:0] ch);
    logic [5:0] code;
    code = CH_SPACE;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      code = CH_0 + 6'(ch - 8'h30);
    end else if (ch >= 8'h41 && ch <= 8'h5A) begin
      code = CH_A + 6'(ch - 8'h41);
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/font_8x8_rom.sv
`default_nettype none
// ============================================================================
//  Module      : font_8x8_rom
//  Description : 8x8 base font, combinational. Returns one glyph row for a
//                6-bit character code; bit 7 is the leftmost pixel, row 0 is
//                the top row. Codes outside 0..36 render blank.
//  Ports       : i_code [5:0] character code
//                i_row  [2:0] glyph row
//                o_bits [7:0] glyph row pixels
//  Revision    : 1.0  initial release
// ============================================================================
module font_8x8_rom
  import score_reset_pkg::*;
(
  input  logic [5:0] i_code,
  input  logic [2:0] i_row,
  output logic [7:0] o_bits
);

  // Whole glyph, top row in the most significant byte.
  logic [63:0] w_glyph;

  always_comb begin
    w_glyph = 64'h0;
    case (i_code)
      6'd1:    w_glyph = 64'h3C666E7666663C00; // 0
      6'd2:    w_glyph = 64'h1838181818187E00; // 1
      6'd3:    w_glyph = 64'h3C66060C30607E00; // 2
      6'd4:    w_glyph = 64'h3C66061C06663C00; // 3
      6'd5:    w_glyph = 64'h0C1C2C4C7E0C0C00; // 4
      6'd6:    w_glyph = 64'h7E607C0606663C00; // 5
      6'd7:    w_glyph = 64'h3C607C6666663C00; // 6
      6'd8:    w_glyph = 64'h7E060C1830303000; // 7
      6'd9:    w_glyph = 64'h3C66663C66663C00; // 8
      6'd10:   w_glyph = 64'h3C66663E060C3800; // 9
      6'd11:   w_glyph = 64'h183C66667E666600; // A
      6'd12:   w_glyph = 64'h7C66667C66667C00; // B
      6'd13:   w_glyph = 64'h3C66606060663C00; // C
      6'd14:   w_glyph = 64'h786C6666666C7800; // D
      6'd15:   w_glyph = 64'h7E60607C60607E00; // E
      6'd16:   w_glyph = 64'h7E60607C60606000; // F
      6'd17:   w_glyph = 64'h3C66606E66663C00; // G
      6'd18:   w_glyph = 64'h6666667E66666600; // H
      6'd19:   w_glyph = 64'h3C18181818183C00; // I
      6'd20:   w_glyph = 64'h1E0C0C0C0C6C3800; // J
      6'd21:   w_glyph = 64'h666C7870786C6600; // K
      6'd22:   w_glyph = 64'h6060606060607E00; // L
      6'd23:   w_glyph = 64'h63777F6B63636300; // M
      6'd24:   w_glyph = 64'h66767E7E6E666600; // N
      6'd25:   w_glyph = 64'h3C66666666663C00; // O
      6'd26:   w_glyph = 64'h7C66667C60606000; // P
      6'd27:   w_glyph = 64'h3C666666663C0E00; // Q
      6'd28:   w_glyph = 64'h7C66667C786C6600; // R
      6'd29:   w_glyph = 64'h3C66603C06663C00; // S
      6'd30:   w_glyph = 64'h7E18181818181800; // T
      6'd31:   w_glyph = 64'h6666666666663C00; // U
      6'd32:   w_glyph = 64'h66666666663C1800; // V
      6'd33:   w_glyph = 64'h6363636B7F776300; // W
      6'd34:   w_glyph = 64'h66663C183C666600; // X
      6'd35:   w_glyph = 64'h6666663C18181800; // Y
      6'd36:   w_glyph = 64'h7E060C1830607E00; // Z
      default: w_glyph = 64'h0;                // space and unused codes
    endcase
  end

  assign o_bits = w_glyph[8*(7-int'(i_row)) +: 8];

endmodule
`default_nettype wire

// File: rtl/score_reset_char_gen.sv
`default_nettype none
// ============================================================================
//  Module      : score_reset_char_gen
//  Description : Character/font responder for the end-of-game score panel.
//                Decodes the requested cell into a character code, delays it
//                through a two-stage code pipeline, then scales the 8x8 font
//                row to a 40-pixel row. Converts the score to BCD with a
//                sequential double-dabble engine on every game end.
//  Ports       : pclk         pixel clock
//                rst_n        synchronous active-low reset
//                char_yx      {row, col} of the requested cell
//                char_line    pixel line within the cell, 0..39
//                score        binary score, sampled at conversion start
//                game_over    end flag, priority over victory
//                victory      end flag
//                char_pixels  glyph row, bit 39 leftmost
//                digits_valid BCD score digits are current
//  Revision    : 1.0  initial release
// ============================================================================
module score_reset_char_gen
  import score_reset_pkg::*;
#(
  parameter int SCORE_W = 14,
  parameter int SCALE   = 5
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic [7:0]           char_yx,
  input  logic [7:0]           char_line,
  input  logic [SCORE_W-1:0]   score,
  input  logic                 game_over,
  input  logic                 victory,
  output logic [8*SCALE-1:0]   char_pixels,
  output logic                 digits_valid
);

  // Shift register holds {BCD[15:0], binary[SCORE_W-1:0]}.
  localparam int SR_W  = SCORE_W + 16;
  localparam int CNT_W = $clog2(SCORE_W);

  localparam logic [CNT_W-1:0]   c_last_step = CNT_W'(SCORE_W - 1);
  localparam logic [SCORE_W-1:0] c_max_score = SCORE_W'(MAX_SCORE);

  // --------------------------------------------------------------------------
  // BCD conversion FSM
  // --------------------------------------------------------------------------
  bcd_state_t          r_state;
  bcd_state_t          w_state_next;
  logic                r_g_q;
  logic [SR_W-1:0]     r_sr;
  logic [SR_W-1:0]     w_sr_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [15:0]         r_digits;
  logic [15:0]         w_digits_next;
  logic                r_digits_valid;
  logic                w_valid_next;

  logic                w_g;
  logic                w_rise;
  logic [SCORE_W-1:0]  w_load_val;
  logic [SR_W-1:0]     w_adj;
  logic [SR_W-1:0]     w_shift;

  assign w_g        = game_over | victory;
  assign w_rise     = w_g & ~r_g_q;
  assign w_load_val = (score > c_max_score) ? c_max_score : score;

  // One double-dabble step: correct every BCD nibble >= 5, then shift.
  always_comb begin
    w_adj = r_sr;
    for (int k = 0; k < 4; k++) begin
      if (r_sr[SCORE_W + 4*k +: 4] >= 4'd5) begin
        w_adj[SCORE_W + 4*k +: 4] = r_sr[SCORE_W + 4*k +: 4] + 4'd3;
      end
    end
    w_shift = w_adj << 1;
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_g_q          <= 1'b0;
      r_sr           <= '0;
      r_cnt          <= '0;
      r_digits       <= 16'h0;
      r_digits_valid <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_g_q          <= w_g;
      r_sr           <= w_sr_next;
      r_cnt          <= w_cnt_next;
      r_digits       <= w_digits_next;
      r_digits_valid <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_sr_next     = r_sr;
    w_cnt_next    = r_cnt;
    w_digits_next = r_digits;
    w_valid_next  = r_digits_valid;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        if (!w_g) begin
          w_state_next = IDLE;
          w_valid_next = 1'b0;
        end else begin
          w_sr_next    = {16'h0, w_load_val};
          w_cnt_next   = '0;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        // A falling end flag aborts without touching the digits register.
        if (!w_g) begin
          w_state_next = IDLE;
          w_valid_next = 1'b0;
        end else begin
          w_sr_next  = w_shift;
          w_cnt_next = r_cnt + CNT_W'(1);
          if (r_cnt == c_last_step) begin
            w_digits_next = w_shift[SR_W-1 -: 16];
            w_valid_next  = 1'b1;
            w_state_next  = DONE;
          end
        end
      end
      DONE: begin
        if (!w_g) begin
          w_state_next = IDLE;
          w_valid_next = 1'b0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_valid_next = 1'b0;
      end
    endcase
  end

  assign digits_valid = r_digits_valid;

  // --------------------------------------------------------------------------
  // Text map decode (cell -> character code)
  // --------------------------------------------------------------------------
  logic [3:0] w_row;
  logic [3:0] w_col;
  logic [1:0] w_digit_idx;
  logic [3:0] w_shown;
  logic [7:0] w_ch;
  logic [5:0] w_code;
  logic [5:0] r_code1;
  logic [5:0] r_code2;

  assign w_row = char_yx[7:4];
  assign w_col = char_yx[3:0];

  // Leading-zero blanking: a digit shows if it or any higher digit is
  // non-zero; the units digit (index 0) always shows.
  assign w_shown = {|r_digits[15:12], |r_digits[15:8], |r_digits[15:4], 1'b1};

  always_comb begin
    w_ch        = 8'h20;
    // Column 13 is the units digit (nibble 0), column 10 the thousands.
    w_digit_idx = 2'(4'd13 - w_col);
    if (int'(w_row) < ROWS) begin
      case (w_row)
        4'd1: begin
          if (game_over) begin
            w_ch = text_char(c_txt_game_over, w_col);
          end else if (victory) begin
            w_ch = text_char(c_txt_you_win, w_col);
          end
        end
        4'd3: begin
          if (w_col >= 4'd10 && w_col <= 4'd13) begin
            if (r_digits_valid && w_shown[w_digit_idx]) begin
              w_ch = 8'h30 + {4'h0, r_digits[4*w_digit_idx +: 4]};
            end
          end else begin
            w_ch = text_char(c_txt_score, w_col);
          end
        end
        4'd4:    w_ch = text_char(c_txt_press, w_col);
        default: w_ch = 8'h20;
      endcase
    end
  end

  assign w_code = ascii_to_code(w_ch);

  // Two-stage code pipeline lines the code up with the overlay's char_line.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_code1 <= CH_SPACE;
      r_code2 <= CH_SPACE;
    end else begin
      r_code1 <= w_code;
      r_code2 <= r_code1;
    end
  end

  // --------------------------------------------------------------------------
  // Font lookup and horizontal/vertical scaling
  // --------------------------------------------------------------------------
  logic       w_line_ok;
  logic [2:0] w_glyph_row;
  logic [7:0] w_font_bits;

  assign w_line_ok   = (char_line < 8'(CELL));
  assign w_glyph_row = 3'(char_line / 8'(SCALE));

  font_8x8_rom u_font (
    .i_code (r_code2),
    .i_row  (w_glyph_row),
    .o_bits (w_font_bits)
  );

  // Each font pixel is replicated SCALE times across the row.
  for (genvar i = 0; i < 8*SCALE; i++) begin : g_px
    assign char_pixels[8*SCALE-1-i] = w_line_ok & w_font_bits[7 - i/SCALE];
  end

endmodule
`default_nettype wire

// File: tb/tb_score_reset_char_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_reset_char_gen
//  Description : Self-checking bench for score_reset_char_gen. Requests are
//                issued with their expected glyph row pushed onto a queue; a
//                monitor pops and compares when the response is due.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_score_reset_char_gen;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic [7:0]  char_yx;
  logic [7:0]  char_line;
  logic [13:0] score;
  logic        game_over;
  logic        victory;
  logic [39:0] char_pixels;
  logic        digits_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [39:0] px;
    logic [7:0]  yx;
    logic [7:0]  line;
  } exp_t;

  exp_t exp_q[$];

  logic       req_v = 1'b0;
  logic       tb_v1 = 1'b0;
  logic       tb_v2 = 1'b0;
  logic [7:0] lp1   = 8'h0;
  logic [7:0] lp2   = 8'h0;

  always #5 pclk = ~pclk;

  score_reset_char_gen #(
    .SCORE_W (14),
    .SCALE   (5)
  ) dut (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .char_yx      (char_yx),
    .char_line    (char_line),
    .score        (score),
    .game_over    (game_over),
    .victory      (victory),
    .char_pixels  (char_pixels),
    .digits_valid (digits_valid)
  );

  // Hand-entered glyphs for the characters the bench looks at.
  function automatic logic [63:0] glyph(input byte ch);
    case (ch)
      "1":     return 64'h1838181818187E00;
      "2":     return 64'h3C66060C30607E00;
      "3":     return 64'h3C66061C06663C00;
      "4":     return 64'h0C1C2C4C7E0C0C00;
      "7":     return 64'h7E060C1830303000;
      "9":     return 64'h3C66663E060C3800;
      "G":     return 64'h3C66606E66663C00;
      "O":     return 64'h3C66666666663C00;
      "S":     return 64'h3C66603C06663C00;
      "P":     return 64'h7C66667C60606000;
      "Y":     return 64'h6666663C18181800;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [39:0] exp_px(input byte ch, input logic [7:0] line);
    logic [63:0] f;
    logic [7:0]  rb;
    logic [39:0] p;
    int          r;
    p = 40'h0;
    if (line < 8'd40) begin
      f  = glyph(ch);
      r  = int'(line) / 5;
      rb = f[63-8*r -: 8];
      for (int i = 0; i < 40; i++) p[39-i] = rb[7 - i/5];
    end
    return p;
  endfunction

  // Response arrives two cycles after the request cycle.
  always @(posedge pclk) begin
    tb_v1 <= req_v;
    tb_v2 <= tb_v1;
  end

  always @(negedge pclk) begin
    if (tb_v2) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pixels: response due but scoreboard empty, got %010h", char_pixels);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (char_pixels !== e.px) begin
          n_fail++;
          $display("FAIL pixels yx=%02h line=%0d: got %010h required %010h",
                   e.yx, e.line, char_pixels, e.px);
        end
      end
    end
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b required %0b", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // One request slot; char_line is driven with the line of the request made
  // two slots earlier so it lines up with that request's output cycle.
  task automatic tick(input logic v, input logic [7:0] yx, input logic [7:0] line,
                      input logic [39:0] exp);
    exp_t e;
    char_yx   = yx;
    req_v     = v;
    char_line = lp2;
    lp2       = lp1;
    lp1       = line;
    if (v) begin
      e.px = exp;
      e.yx = yx;
      e.line = line;
      exp_q.push_back(e);
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic req(input logic [7:0] yx, input logic [7:0] line, input byte ch);
    tick(1'b1, yx, line, exp_px(ch, line));
  endtask

  task automatic drain();
    tick(1'b0, 8'h00, 8'h00, 40'h0);
    tick(1'b0, 8'h00, 8'h00, 40'h0);
  endtask

  task automatic go_idle();
    game_over = 1'b0;
    victory   = 1'b0;
    cyc(2);
    check_bit("valid_cleared_in_idle", digits_valid, 1'b0);
  endtask

  // Rising edge of game_over is sampled at edge E; valid must rise at E+15.
  task automatic convert(input logic [13:0] s);
    score     = s;
    game_over = 1'b1;
    @(posedge pclk);
    #1;
    cyc(1);
    score = 14'h3FFF ^ s;   // must not disturb the conversion
    cyc(13);
    check_bit("valid_at_E+14", digits_valid, 1'b0);
    cyc(1);
    check_bit("valid_at_E+15", digits_valid, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    char_yx   = 8'h00;
    char_line = 8'h00;
    score     = 14'd0;
    game_over = 1'b0;
    victory   = 1'b0;

    // Reset: pipeline holds spaces, nothing lights up.
    cyc(3);
    check_bit("reset_valid", digits_valid, 1'b0);
    for (int a = 0; a < 96; a++) req(8'(a), 8'((a * 7) % 40), " ");
    drain();
    check_bit("reset_valid_after_sweep", digits_valid, 1'b0);

    // Static text with no flags and no digits.
    rst_n = 1'b1;
    cyc(1);
    req(8'h13, 8'd0,  " ");
    req(8'h33, 8'd7,  "S");
    req(8'h42, 8'd20, "P");
    req(8'h3D, 8'd0,  " ");
    req(8'h73, 8'd5,  " ");
    drain();

    // Score 1234.
    convert(14'd1234);
    req(8'h3A, 8'd0,  "1");
    req(8'h3B, 8'd6,  "2");
    req(8'h3C, 8'd17, "3");
    req(8'h3D, 8'd33, "4");
    req(8'h3A, 8'd39, "1");
    req(8'h3D, 8'd12, "4");
    drain();

    // Score 7: leading zeros blank.
    go_idle();
    convert(14'd7);
    req(8'h3A, 8'd10, " ");
    req(8'h3B, 8'd10, " ");
    req(8'h3C, 8'd10, " ");
    req(8'h3D, 8'd0,  "7");
    req(8'h3D, 8'd5,  "7");
    req(8'h3D, 8'd10, "7");
    req(8'h3D, 8'd30, "7");
    drain();

    // Score 12000 saturates to 9999.
    go_idle();
    convert(14'd12000);
    req(8'h3A, 8'd3,  "9");
    req(8'h3B, 8'd22, "9");
    req(8'h3C, 8'd3,  "9");
    req(8'h3D, 8'd22, "9");
    drain();

    // Priority: both flags -> GAME OVER; back-to-back requests.
    victory = 1'b1;
    req(8'h13, 8'd0,  "G");
    req(8'h10, 8'd0,  " ");
    req(8'h19, 8'd12, "O");
    req(8'h3D, 8'd3,  "9");
    req(8'h13, 8'd25, "G");
    req(8'h33, 8'd0,  "S");
    req(8'h13, 8'd39, "G");
    drain();

    // Victory alone: flag stays high, conversion result held.
    game_over = 1'b0;
    cyc(2);
    check_bit("done_hold_valid", digits_valid, 1'b1);
    req(8'h14, 8'd5, "Y");
    req(8'h13, 8'd5, " ");
    req(8'h3D, 8'd3, "9");
    drain();

    // Abort: drop the flag so it is sampled low at E+8.
    go_idle();
    score     = 14'd1111;
    game_over = 1'b1;
    @(posedge pclk);
    #1;
    cyc(7);
    game_over = 1'b0;
    cyc(10);
    check_bit("abort_valid", digits_valid, 1'b0);
    convert(14'd4321);
    req(8'h3A, 8'd0, "4");
    req(8'h3B, 8'd0, "3");
    req(8'h3C, 8'd0, "2");
    req(8'h3D, 8'd0, "1");
    drain();

    // Bounds: lines past the cell and rows past the panel are blank.
    req(8'h3D, 8'd40,  " ");
    req(8'h3D, 8'd255, " ");
    req(8'h73, 8'd0,   " ");
    req(8'h7A, 8'd8,   " ");
    req(8'hF3, 8'd0,   " ");
    drain();

    // Reset while a result is displayed.
    rst_n = 1'b0;
    cyc(1);
    check_bit("reset_in_done_valid", digits_valid, 1'b0);
    req(8'h3D, 8'd0, " ");
    req(8'h42, 8'd20, " ");
    drain();
    game_over = 1'b0;
    rst_n     = 1'b1;
    cyc(3);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
